// File: rtl/hazard_pkg.sv
// hazard_pkg: encodings and default constants for the ID-stage hazard
// scoreboard. The decoder drives id_*_tnew / id_*_tuse from the T_* and
// TUSE_* values here; the scoreboard uses the default latency constants.
//   T_*    : cycles, counted from EX, until a result can be forwarded.
//   TUSE_* : cycles, counted from ID, until an operand is actually consumed.
package hazard_pkg;

  localparam int T_ALU       = 1;
  localparam int T_LOAD      = 2;
  localparam int TUSE_BRANCH = 0;
  localparam int TUSE_ALU    = 1;

  localparam int DEF_NREG     = 32;
  localparam int DEF_AW       = 5;
  localparam int DEF_NSRC     = 2;
  localparam int DEF_TW       = 2;
  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int DEF_EPC_TNEW = 2;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_down_counter.sv
// sat_down_counter: loadable, clearable down-counter that sticks at zero.
// Priority on each edge: load, then clear, then decrement (if nonzero).
// Ports:
//   clk, rst   clock, asynchronous active-high reset (count -> 0)
//   load       load load_val on this edge
//   load_val   value to load
//   clear      force count to 0 on this edge (ignored when load=1)
//   count      current count (registered)
module sat_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall generator for the 5-stage MIPS core.
// Each GPR has a countdown loaded with the producer's Tnew when it issues;
// a source stalls while its producer's count exceeds the source's Tuse.
// HI/LO (mult/div) and EPC (mtc0 -> eret) have their own countdowns.
//
// Handshake: the instruction held in ID leaves ID (issues) on a clock edge
// where id_valid=1 and stall=0. Only an issuing instruction updates the
// counters. stall is never asserted when id_valid=0.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   id_valid        ID holds a real instruction
//   id_src_en       per-source read enable (NSRC bits)
//   id_src_addr     packed source addresses, source k at [k*AW +: AW]
//   id_src_tuse     packed source Tuse, source k at [k*TW +: TW]
//   id_dst_en       instruction writes a GPR
//   id_dst_addr     destination GPR
//   id_dst_tnew     destination Tnew (measured at EX)
//   id_md_start     mult/multu/div/divu
//   id_md_div       with id_md_start: use the divide latency
//   id_hilo_use     instruction reads or writes HI/LO
//   id_epc_wr       mtc0 to EPC
//   id_epc_use      eret
//   md_cancel       exception kills the in-flight mult/div
//   stall           combinational stall request
//   md_busy         HI/LO unit busy (registered)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = DEF_NREG,
  parameter int AW       = DEF_AW,
  parameter int NSRC     = DEF_NSRC,
  parameter int TW       = DEF_TW,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int EPC_TNEW = DEF_EPC_TNEW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [NSRC-1:0]    id_src_en,
  input  logic [NSRC*AW-1:0] id_src_addr,
  input  logic [NSRC*TW-1:0] id_src_tuse,
  input  logic               id_dst_en,
  input  logic [AW-1:0]      id_dst_addr,
  input  logic [TW-1:0]      id_dst_tnew,
  input  logic               id_md_start,
  input  logic               id_md_div,
  input  logic               id_hilo_use,
  input  logic               id_epc_wr,
  input  logic               id_epc_use,
  input  logic               md_cancel,
  output logic               stall,
  output logic               md_busy
);

  localparam int MDW  = cnt_width(DIV_LAT);
  localparam int EPCW = cnt_width(EPC_TNEW);

  logic issue;
  assign issue = id_valid & ~stall;

  // ---------------- GPR scoreboard ----------------
  logic [TW-1:0] cnt [NREG];

  // $0 is hardwired and never produces a hazard.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic ld;
    assign ld = issue & id_dst_en & (id_dst_addr == AW'(r));
    sat_down_counter #(.W(TW)) u_cnt (
      .clk      (clk),
      .rst      (reset),
      .load     (ld),
      .load_val (id_dst_tnew),
      .clear    (1'b0),
      .count    (cnt[r])
    );
  end

  // Sources compare against the pre-update count, so an instruction never
  // sees its own destination load.
  logic [NSRC-1:0] src_stall;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [AW-1:0] addr;
    logic [TW-1:0] tuse;
    assign addr = id_src_addr[k*AW +: AW];
    assign tuse = id_src_tuse[k*TW +: TW];
    assign src_stall[k] = id_valid & id_src_en[k] & (addr != '0) &
                          (cnt[addr] > tuse);
  end

  // ---------------- HI/LO busy tracker ----------------
  logic [MDW-1:0] md_cnt;
  logic [MDW-1:0] md_lat;
  logic           md_load;
  logic           md_busy_next;

  assign md_load = issue & id_md_start;
  assign md_lat  = id_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);

  sat_down_counter #(.W(MDW)) u_md_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (md_load),
    .load_val (md_lat),
    .clear    (md_cancel),
    .count    (md_cnt)
  );

  // md_busy mirrors (md_cnt != 0) one edge early so it is a clean flop.
  // A new start wins over a cancel in the same cycle.
  always_comb begin
    md_busy_next = 1'b0;
    if (md_load) begin
      md_busy_next = (md_lat != '0);
    end else if (md_cancel) begin
      md_busy_next = 1'b0;
    end else begin
      md_busy_next = (md_cnt > MDW'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_busy <= 1'b0;
    end else begin
      md_busy <= md_busy_next;
    end
  end

  // ---------------- EPC write tracker ----------------
  logic [EPCW-1:0] epc_cnt;
  logic            epc_load;

  assign epc_load = issue & id_epc_wr;

  sat_down_counter #(.W(EPCW)) u_epc_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (epc_load),
    .load_val (EPCW'(EPC_TNEW)),
    .clear    (1'b0),
    .count    (epc_cnt)
  );

  // ---------------- stall ----------------
  logic hilo_stall;
  logic epc_stall;

  assign hilo_stall = id_valid & id_hilo_use & md_busy;
  assign epc_stall  = id_valid & id_epc_use & (epc_cnt != '0);
  assign stall      = (|src_stall) | hilo_stall | epc_stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. The reference model works in absolute cycle
// numbers: each tracked resource remembers the first cycle at which a
// consumer may proceed, and stall/md_busy are derived from that.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int NSRC     = 2;
  localparam int TW       = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int EPC_TNEW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic               clk;
  logic               reset;
  logic               id_valid;
  logic [NSRC-1:0]    id_src_en;
  logic [NSRC*AW-1:0] id_src_addr;
  logic [NSRC*TW-1:0] id_src_tuse;
  logic               id_dst_en;
  logic [AW-1:0]      id_dst_addr;
  logic [TW-1:0]      id_dst_tnew;
  logic               id_md_start;
  logic               id_md_div;
  logic               id_hilo_use;
  logic               id_epc_wr;
  logic               id_epc_use;
  logic               md_cancel;
  logic               stall;
  logic               md_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .NSRC(NSRC), .TW(TW),
    .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .EPC_TNEW(EPC_TNEW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_src_en   (id_src_en),
    .id_src_addr (id_src_addr),
    .id_src_tuse (id_src_tuse),
    .id_dst_en   (id_dst_en),
    .id_dst_addr (id_dst_addr),
    .id_dst_tnew (id_dst_tnew),
    .id_md_start (id_md_start),
    .id_md_div   (id_md_div),
    .id_hilo_use (id_hilo_use),
    .id_epc_wr   (id_epc_wr),
    .id_epc_use  (id_epc_use),
    .md_cancel   (md_cancel),
    .stall       (stall),
    .md_busy     (md_busy)
  );

  // ---------------- instruction record ----------------
  typedef struct {
    bit       valid;
    bit       en0, en1;
    bit [4:0] a0, a1;
    bit [1:0] t0, t1;
    bit       dst_en;
    bit [4:0] dst;
    bit [1:0] tnew;
    bit       md_start, md_div, hilo, epc_wr, epc_use, cancel;
  } ins_t;

  function automatic ins_t nop();
    ins_t x;
    x.valid = 0; x.en0 = 0; x.en1 = 0; x.a0 = 0; x.a1 = 0; x.t0 = 0; x.t1 = 0;
    x.dst_en = 0; x.dst = 0; x.tnew = 0; x.md_start = 0; x.md_div = 0;
    x.hilo = 0; x.epc_wr = 0; x.epc_use = 0; x.cancel = 0;
    return x;
  endfunction

  function automatic ins_t op(input bit [4:0] d, input int tn,
                              input bit [4:0] s0, input int u0,
                              input bit [4:0] s1, input int u1);
    ins_t x = nop();
    x.valid = 1; x.dst_en = 1; x.dst = d; x.tnew = 2'(tn);
    x.en0 = 1; x.a0 = s0; x.t0 = 2'(u0);
    x.en1 = 1; x.a1 = s1; x.t1 = 2'(u1);
    return x;
  endfunction

  function automatic ins_t rand_ins();
    ins_t x = nop();
    x.valid    = ($urandom_range(0, 99) < 85);
    x.en0      = 1'($urandom_range(0, 1));
    x.a0       = 5'($urandom_range(0, 3));
    x.t0       = 2'($urandom_range(0, 3));
    x.en1      = 1'($urandom_range(0, 1));
    x.a1       = 5'($urandom_range(0, 3));
    x.t1       = 2'($urandom_range(0, 3));
    x.dst_en   = 1'($urandom_range(0, 1));
    x.dst      = 5'($urandom_range(0, 3));
    x.tnew     = 2'($urandom_range(0, 3));
    x.md_start = ($urandom_range(0, 9) == 0);
    x.md_div   = 1'($urandom_range(0, 1));
    x.hilo     = x.md_start | ($urandom_range(0, 4) == 0);
    x.epc_wr   = ($urandom_range(0, 7) == 0);
    x.epc_use  = ($urandom_range(0, 5) == 0);
    x.cancel   = ($urandom_range(0, 19) == 0);
    return x;
  endfunction

  // ---------------- reference model ----------------
  int cyc;
  int reg_ready [NREG];   // first cycle at which cnt[r] <= tuse for tuse=0
  int md_free_at;         // first cycle with HI/LO free
  int epc_ready_at;       // first cycle eret may proceed

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) reg_ready[r] = 0;
    md_free_at   = 0;
    epc_ready_at = 0;
  endfunction

  // A producer issued in cycle i with Tnew t still counts t-(c-i-1) in
  // cycle c; a consumer waits while that exceeds its Tuse, i.e. while
  // c + tuse < i + 1 + t.
  function automatic bit model_stall(input ins_t x);
    bit s = 0;
    if (!x.valid) return 0;
    if (x.en0 && x.a0 != 0 && cyc + int'(x.t0) < reg_ready[x.a0]) s = 1;
    if (x.en1 && x.a1 != 0 && cyc + int'(x.t1) < reg_ready[x.a1]) s = 1;
    if (x.hilo && cyc < md_free_at) s = 1;
    if (x.epc_use && cyc < epc_ready_at) s = 1;
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q [$];   // {md_busy, stall}
  int n_checks;
  int n_pass;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      check(stall == e[0], "stall", int'(stall), int'(e[0]));
      check(md_busy == e[1], "md_busy", int'(md_busy), int'(e[1]));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input ins_t x);
    id_valid    = x.valid;
    id_src_en   = {x.en1, x.en0};
    id_src_addr = {x.a1, x.a0};
    id_src_tuse = {x.t1, x.t0};
    id_dst_en   = x.dst_en;
    id_dst_addr = x.dst;
    id_dst_tnew = x.tnew;
    id_md_start = x.md_start;
    id_md_div   = x.md_div;
    id_hilo_use = x.hilo;
    id_epc_wr   = x.epc_wr;
    id_epc_use  = x.epc_use;
    md_cancel   = x.cancel;
  endtask

  // One cycle: drive, queue the expected outputs, advance the model.
  task automatic step(input ins_t x, output bit dut_stall);
    bit es, eb, iss;
    @(posedge clk);
    cyc++;
    #1;
    drive(x);
    es = model_stall(x);
    eb = (cyc < md_free_at);
    exp_q.push_back({eb, es});
    #1;
    dut_stall = stall;
    iss = x.valid && !es;
    if (iss && x.dst_en && x.dst != 0) reg_ready[x.dst] = cyc + 1 + int'(x.tnew);
    if (iss && x.md_start) md_free_at = cyc + 1 + (x.md_div ? DIV_LAT : MULT_LAT);
    else if (x.cancel && md_free_at > cyc + 1) md_free_at = cyc + 1;
    if (iss && x.epc_wr) epc_ready_at = cyc + 1 + EPC_TNEW;
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) step(nop(), s);
  endtask

  // Hold x in ID until it issues; compare the number of stall cycles seen
  // on the DUT. md_cancel is raised on stall cycle number cancel_at.
  task automatic do_issue(input ins_t x, input int exp_stalls,
                          input int cancel_at, input string name);
    ins_t y;
    bit s;
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      y = x;
      y.cancel = (n == cancel_at);
      step(y, s);
      if (s) n++;
      else done = 1;
    end
    if (!done) check(0, {name, "_timeout"}, n, exp_stalls);
    else check(n == exp_stalls, name, n, exp_stalls);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ins_t x, mflo, div_i, mult_i, mtc0, eret, beq;
    bit s;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    model_reset();

    // Reset asserted with a hazard-looking instruction in ID.
    reset = 1'b1;
    x = op(9, T_ALU, 8, TUSE_BRANCH, 0, 0);
    x.hilo = 1; x.epc_use = 1;
    drive(x);
    #3;
    check(stall == 1'b0, "reset_stall", int'(stall), 0);
    check(md_busy == 1'b0, "reset_md_busy", int'(md_busy), 0);
    #9;
    reset = 1'b0;
    drive(nop());
    idle(2);

    // Load-use: lw $8 then add $9,$8,$1.
    step(op(8, T_LOAD, 0, 0, 0, 0), s);
    do_issue(op(9, T_ALU, 8, TUSE_ALU, 1, TUSE_ALU), 1, -1, "load_use");

    // Branch after ALU, then after load.
    beq = op(0, 0, 5, TUSE_BRANCH, 0, TUSE_BRANCH);
    beq.dst_en = 0;
    step(op(5, T_ALU, 0, 0, 0, 0), s);
    do_issue(beq, 1, -1, "branch_after_alu");
    step(op(5, T_LOAD, 0, 0, 0, 0), s);
    do_issue(beq, 2, -1, "branch_after_load");

    // Newest writer wins.
    step(op(3, T_LOAD, 0, 0, 0, 0), s);
    step(op(3, T_ALU, 0, 0, 0, 0), s);
    do_issue(op(10, T_ALU, 3, TUSE_ALU, 0, 0), 0, -1, "newest_writer");

    // mult/div against mflo.
    div_i = nop();
    div_i.valid = 1; div_i.md_start = 1; div_i.md_div = 1; div_i.hilo = 1;
    mult_i = div_i;
    mult_i.md_div = 0;
    mflo = op(2, T_ALU, 0, 0, 0, 0);
    mflo.hilo = 1;
    step(div_i, s);
    do_issue(mflo, DIV_LAT, -1, "div_mflo");
    step(mult_i, s);
    do_issue(mflo, MULT_LAT, -1, "mult_mflo");
    step(div_i, s);
    do_issue(mflo, 3, 2, "div_cancel");

    // mtc0 EPC then eret: stalls while the EPC count is nonzero.
    mtc0 = nop();
    mtc0.valid = 1; mtc0.epc_wr = 1;
    eret = nop();
    eret.valid = 1; eret.epc_use = 1;
    step(mtc0, s);
    do_issue(eret, EPC_TNEW, -1, "eret_next");
    step(mtc0, s);
    idle(1);
    do_issue(eret, EPC_TNEW - 1, -1, "eret_later");

    // Producer to $0 never creates a hazard.
    step(op(0, T_LOAD, 0, 0, 0, 0), s);
    do_issue(op(6, T_ALU, 0, TUSE_BRANCH, 0, TUSE_BRANCH), 0, -1, "reg0");

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) step(rand_ins(), s);

    // Reset mid-operation with md_busy=1 and cnt[8]=2.
    idle(DIV_LAT + 2);
    step(div_i, s);
    step(op(8, T_LOAD, 0, 0, 0, 0), s);
    @(posedge clk);
    cyc++;
    #1;
    x = op(9, T_ALU, 8, TUSE_ALU, 0, 0);
    x.hilo = 1;
    drive(x);
    #1;
    check(stall == 1'b1, "pre_reset_stall", int'(stall), 1);
    check(md_busy == 1'b1, "pre_reset_md_busy", int'(md_busy), 1);
    reset = 1'b1;
    #1;
    check(stall == 1'b0, "async_reset_stall", int'(stall), 0);
    check(md_busy == 1'b0, "async_reset_md_busy", int'(md_busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(nop());
    do_issue(x, 0, -1, "after_reset");

    for (int i = 0; i < 100; i++) step(rand_ins(), s);
    drive(nop());

    repeat (2) @(negedge clk);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
